// File: rtl/sata_oob_pkg.sv
// Shared OOB definitions: command encodings, sequencer states, unit-interval
// lengths and the UI-to-clock-cycle conversion used by generator and detector.
package sata_oob_pkg;

   typedef enum logic [1:0] {
      OOB_INIT = 2'd0,
      OOB_WAKE = 2'd1,
      OOB_SAS  = 2'd2,
      OOB_NOP  = 2'd3
   } oob_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } oob_state_t;

   localparam int UI_BURST   = 160;
   localparam int UI_GAPINIT = 480;
   localparam int UI_GAPWAKE = 160;
   localparam int UI_GAPSAS  = 1440;

   // Round-to-nearest conversion of a UI count into clk cycles (kHz units).
   function automatic int oob_cycles(input int ui, input int clkfreq, input int reffreq);
      longint num;
      num = longint'(ui) * longint'(clkfreq) + longint'(reffreq / 2);
      return int'(num / longint'(reffreq));
   endfunction

endpackage

// File: rtl/sata_oob_sequencer.sv
// OOB burst/gap sequencer: drives transceiver TX electrical idle to produce
// COMINIT/COMRESET, COMWAKE and COMSAS patterns from a valid/ready command.
// Handshake: a command is taken on a clock edge where cmd_valid and cmd_ready
// are both high; cmd_ready is high only in idle while abort is low.
module sata_oob_sequencer
   import sata_oob_pkg::*;
#(
   parameter int CLKFREQ  = 100_000,
   parameter int REFFREQ  = 1_500_000,
   parameter int BURSTS   = 6,
   parameter int TRAILGAP = 1
) (
   input  logic       reset,
   input  logic       clk,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_type,
   output logic       cmd_ready,
   input  logic       abort,
   input  logic       oobfinish,
   output logic       txelecidle,
   output logic       burst_active,
   output logic       done
);

   localparam int BURSTLEN = oob_cycles(UI_BURST,   CLKFREQ, REFFREQ);
   localparam int GAPINIT  = oob_cycles(UI_GAPINIT, CLKFREQ, REFFREQ);
   localparam int GAPWAKE  = oob_cycles(UI_GAPWAKE, CLKFREQ, REFFREQ);
   localparam int GAPSAS   = oob_cycles(UI_GAPSAS,  CLKFREQ, REFFREQ);

   // GAPSAS is the longest interval, so it sizes the shared length counter.
   localparam int LW = $clog2(GAPSAS + 1);
   localparam int BW = $clog2(BURSTS + 1);

   localparam logic [LW-1:0] BURST_LAST = LW'(BURSTLEN - 1);
   localparam logic [LW-1:0] INIT_LAST  = LW'(GAPINIT - 1);
   localparam logic [LW-1:0] WAKE_LAST  = LW'(GAPWAKE - 1);
   localparam logic [LW-1:0] SAS_LAST   = LW'(GAPSAS - 1);
   localparam logic [BW-1:0] LAST_BURST = BW'(BURSTS - 1);
   localparam logic [BW-1:0] ALL_BURSTS = BW'(BURSTS);

   if (BURSTLEN < 2 || GAPINIT < 2 || GAPWAKE < 2 || GAPSAS < 2) begin : g_len_check
      $error("sata_oob_sequencer: every OOB length must be at least 2 clk cycles");
   end
   if (BURSTS < 1 || BURSTS > 15) begin : g_burst_check
      $error("sata_oob_sequencer: BURSTS must be in 1..15");
   end
   if (TRAILGAP != 0 && TRAILGAP != 1) begin : g_trail_check
      $error("sata_oob_sequencer: TRAILGAP must be 0 or 1");
   end

   oob_state_t    state, state_nx;
   oob_cmd_t      cmd_q, cmd_nx;
   logic [LW-1:0] len_cnt, len_nx, len_target;
   logic [BW-1:0] burst_cnt, burst_nx;
   logic          len_hit;

   // State, latched command and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd_q     <= OOB_INIT;
         len_cnt   <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         cmd_q     <= cmd_nx;
         len_cnt   <= len_nx;
         burst_cnt <= burst_nx;
      end
   end

   // One comparator: the terminal count is muxed from state and latched type.
   always_comb begin
      len_target = BURST_LAST;
      if (state == ST_GAP) begin
         case (cmd_q)
            OOB_WAKE: len_target = WAKE_LAST;
            OOB_SAS:  len_target = SAS_LAST;
            default:  len_target = INIT_LAST;
         endcase
      end
   end

   assign len_hit = (len_cnt == len_target);

   // Next state, counter updates and handshake/completion outputs.
   always_comb begin
      state_nx  = state;
      cmd_nx    = cmd_q;
      len_nx    = len_cnt;
      burst_nx  = burst_cnt;
      cmd_ready = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = ~abort;
            if (cmd_valid && !abort) begin
               cmd_nx   = oob_cmd_t'(cmd_type);
               state_nx = (oob_cmd_t'(cmd_type) == OOB_NOP) ? ST_DONE : ST_BURST;
            end
         end
         ST_BURST: begin
            if (abort) begin
               state_nx = ST_DONE;
            end else if (len_hit) begin
               len_nx   = '0;
               burst_nx = burst_cnt + BW'(1);
               if (burst_cnt == LAST_BURST && TRAILGAP == 0) state_nx = ST_DONE;
               else                                          state_nx = ST_GAP;
            end else begin
               len_nx = len_cnt + LW'(1);
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nx = ST_DONE;
            end else if (len_hit) begin
               len_nx   = '0;
               state_nx = (burst_cnt == ALL_BURSTS) ? ST_DONE : ST_BURST;
            end else begin
               len_nx = len_cnt + LW'(1);
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            len_nx   = '0;
            burst_nx = '0;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
            len_nx   = '0;
            burst_nx = '0;
         end
      endcase
   end

   assign burst_active = (state == ST_BURST);

   // Registered electrical-idle control; oobfinish forces the transmitter active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) txelecidle <= 1'b1;
      else       txelecidle <= ~((state == ST_BURST) | oobfinish);
   end

endmodule
